// File: rtl/vec_cordic_ctrl.sv
// Sequencer and result buffer for the iterative vectoring CORDIC datapath.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    sample handshake (x_smp, y_smp, z_smp)
//   out_valid/out_ready  result handshake (x_res, y_res)
//   flush                synchronous abort back to IDLE
//   busy                 high while loading or iterating
//   dp_x_in/y_in/z_in    held sample driven to the datapath
//   dp_ce, dp_mux_sel    datapath register enable / 0 = load, 1 = iterate
//   dp_shift_bit         current iteration index
//   dp_sign_in           rotation direction, passed through from dp_sign_fb
//   dp_x_out, dp_y_out   datapath combinational results
module vec_cordic_ctrl #(
    parameter int WIDTH_IN    = 16,
    parameter int WIDTH_OUT   = 18,
    parameter int COUNT_WIDTH = 4,
    parameter int N_ITER      = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH_IN-1:0]  x_smp,
    input  logic signed [WIDTH_IN-1:0]  y_smp,
    input  logic signed [WIDTH_IN-1:0]  z_smp,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH_OUT-1:0] x_res,
    output logic signed [WIDTH_OUT-1:0] y_res,
    input  logic                        flush,
    output logic                        busy,
    output logic signed [WIDTH_IN-1:0]  dp_x_in,
    output logic signed [WIDTH_IN-1:0]  dp_y_in,
    output logic signed [WIDTH_IN-1:0]  dp_z_in,
    output logic                        dp_ce,
    output logic                        dp_mux_sel,
    output logic [COUNT_WIDTH-1:0]      dp_shift_bit,
    output logic                        dp_sign_in,
    input  logic                        dp_sign_fb,
    input  logic signed [WIDTH_OUT-1:0] dp_x_out,
    input  logic signed [WIDTH_OUT-1:0] dp_y_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [COUNT_WIDTH-1:0] K_LAST = COUNT_WIDTH'(N_ITER - 1);
    localparam logic [COUNT_WIDTH-1:0] K_ONE  = COUNT_WIDTH'(1);

    logic [1:0]                 state;
    logic [COUNT_WIDTH-1:0]     k;
    logic signed [WIDTH_IN-1:0] x_hold;
    logic signed [WIDTH_IN-1:0] y_hold;
    logic signed [WIDTH_IN-1:0] z_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            k      <= '0;
            x_hold <= '0;
            y_hold <= '0;
            z_hold <= '0;
            x_res  <= '0;
            y_res  <= '0;
        end else if (flush) begin
            // Abort wins over any handshake in the same cycle.
            state <= S_IDLE;
            k     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_hold <= x_smp;
                        y_hold <= y_smp;
                        z_hold <= z_smp;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    k     <= '0;
                    state <= S_ITER;
                end
                S_ITER: begin
                    // dp_*_out already reflect the final micro-rotation.
                    if (k == K_LAST) begin
                        x_res <= dp_x_out;
                        y_res <= dp_y_out;
                        k     <= '0;
                        state <= S_DONE;
                    end else begin
                        k <= k + K_ONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready     = (state == S_IDLE);
    assign out_valid    = (state == S_DONE);
    assign busy         = (state == S_LOAD) | (state == S_ITER);
    assign dp_ce        = busy;
    assign dp_mux_sel   = (state == S_ITER);
    assign dp_shift_bit = dp_mux_sel ? k : '0;
    assign dp_sign_in   = dp_mux_sel & dp_sign_fb;
    assign dp_x_in      = x_hold;
    assign dp_y_in      = y_hold;
    assign dp_z_in      = z_hold;

endmodule
